// File: rtl/ntt_stage_sequencer_pkg.sv
// Shared definitions for the NTT stage sequencer: arith-unit opcodes, FSM state
// encoding, default data width and the log_n range check.
package ntt_stage_sequencer_pkg;

  localparam int NTT_DATA_W = 64;

  localparam logic [2:0] NTT_OP_ADD  = 3'd0;
  localparam logic [2:0] NTT_OP_MULT = 3'd1;
  localparam logic [2:0] NTT_OP_SUB  = 3'd2;
  localparam logic [2:0] NTT_OP_BF   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_t;

  function automatic logic log_n_ok(input logic [3:0] ln, input int max_ln);
    return (ln != 4'd0) && (int'(ln) <= max_ln);
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Stage/group/j counters for an in-place Cooley-Tukey NTT; j is the innermost
// loop, then group, then stage. Produces butterfly addresses and twiddle index.
module ntt_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [3:0]        log_n,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [ADDR_W-2:0] tw,
  output logic              last_in_stage,
  output logic              last_stage
);

  logic [3:0]        stage;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] m;
  logic [ADDR_W-1:0] last_grp;
  logic [3:0]        tw_sh;
  logic [3:0]        grp_sh;

  // tw_sh = log_n-1-s also gives log2 of the group count in this stage.
  always_comb begin
    m             = ADDR_W'(1) << stage;
    tw_sh         = log_n - 4'd1 - stage;
    grp_sh        = stage + 4'd1;
    last_grp      = (ADDR_W'(1) << tw_sh) - ADDR_W'(1);
    a             = (grp << grp_sh) | j;
    b             = a + m;
    tw            = (ADDR_W-1)'(j << tw_sh);
    last_in_stage = (j == m - ADDR_W'(1)) && (grp == last_grp);
    last_stage    = (stage == log_n - 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stage <= '0;
      grp   <= '0;
      j     <= '0;
    end else if (en) begin
      if (j == m - ADDR_W'(1)) begin
        j <= '0;
        if (grp == last_grp) begin
          grp   <= '0;
          stage <= stage + 4'd1;
        end else begin
          grp <= grp + ADDR_W'(1);
        end
      end else begin
        j <= j + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// In-place iterative NTT sequencer: one butterfly per cycle, read -> arith -> write
// over three cycles, 2-cycle drain between stages. Optional cycle counter: NTT_CYCLE_CNT_EN.
import ntt_stage_sequencer_pkg::*;

module ntt_stage_sequencer #(
  parameter int DATA_W    = NTT_DATA_W,
  parameter int LOG_N_MAX = 12,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        log_n,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycle_cnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr_a,
  output logic [ADDR_W-1:0] mem_rd_addr_b,
  input  logic [DATA_W-1:0] mem_rd_data_a,
  input  logic [DATA_W-1:0] mem_rd_data_b,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr_a,
  output logic [ADDR_W-1:0] mem_wr_addr_b,
  output logic [DATA_W-1:0] mem_wr_data_a,
  output logic [DATA_W-1:0] mem_wr_data_b,
  output logic              tw_rd_en,
  output logic [ADDR_W-2:0] tw_rd_addr,
  input  logic [DATA_W-1:0] tw_rd_data,
  output logic [2:0]        au_opcode,
  output logic [DATA_W-1:0] au_op_a,
  output logic [DATA_W-1:0] au_op_b,
  output logic [DATA_W-1:0] au_op_w,
  output logic [DATA_W-1:0] au_op_q,
  input  logic [DATA_W-1:0] au_res_1,
  input  logic [DATA_W-1:0] au_res_2
);

  seq_state_t        state, state_next;
  logic [3:0]        log_n_reg;
  logic [DATA_W-1:0] q_reg;
  logic              err_reg;
  logic              drain_second;
  logic              final_stage;
  logic              p1_valid, p2_valid;
  logic [ADDR_W-1:0] p1_a, p1_b, p2_a, p2_b;
  logic [ADDR_W-1:0] gen_a, gen_b;
  logic [ADDR_W-2:0] gen_tw;
  logic              gen_last_in_stage, gen_last_stage;
  logic              accept, issue;

  // start is a single-cycle request with no ready: it is taken only in IDLE and dropped otherwise.
  assign accept = (state == ST_IDLE) && start;
  assign issue  = (state == ST_RUN);

  ntt_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .en            (issue),
    .log_n         (log_n_reg),
    .a             (gen_a),
    .b             (gen_b),
    .tw            (gen_tw),
    .last_in_stage (gen_last_in_stage),
    .last_stage    (gen_last_stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      log_n_reg    <= '0;
      q_reg        <= '0;
      err_reg      <= 1'b0;
      drain_second <= 1'b0;
      final_stage  <= 1'b0;
    end else begin
      state        <= state_next;
      drain_second <= (state == ST_DRAIN) && !drain_second;
      if (accept) begin
        log_n_reg <= log_n;
        q_reg     <= q;
        err_reg   <= !log_n_ok(log_n, LOG_N_MAX);
      end
      if (issue && gen_last_in_stage) final_stage <= gen_last_stage;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = log_n_ok(log_n, LOG_N_MAX) ? ST_RUN : ST_ERR;
      ST_RUN:   if (gen_last_in_stage) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_second) state_next = final_stage ? ST_FIN : ST_RUN;
      ST_FIN:   state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Write addresses ride a 2-deep shift register so they line up with au_res_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      p1_a     <= '0;
      p1_b     <= '0;
      p2_a     <= '0;
      p2_b     <= '0;
    end else begin
      p1_valid <= issue;
      p1_a     <= gen_a;
      p1_b     <= gen_b;
      p2_valid <= p1_valid;
      p2_a     <= p1_a;
      p2_b     <= p1_b;
    end
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FIN) || (state == ST_ERR);
  assign err           = err_reg;
  assign mem_rd_en     = issue;
  assign mem_rd_addr_a = issue ? gen_a : '0;
  assign mem_rd_addr_b = issue ? gen_b : '0;
  assign tw_rd_en      = issue;
  assign tw_rd_addr    = issue ? gen_tw : '0;
  assign au_opcode     = NTT_OP_BF;
  assign au_op_a       = p1_valid ? mem_rd_data_a : '0;
  assign au_op_b       = p1_valid ? mem_rd_data_b : '0;
  assign au_op_w       = p1_valid ? tw_rd_data : '0;
  assign au_op_q       = q_reg;
  assign mem_wr_en     = p2_valid;
  assign mem_wr_addr_a = p2_valid ? p2_a : '0;
  assign mem_wr_addr_b = p2_valid ? p2_b : '0;
  assign mem_wr_data_a = p2_valid ? au_res_1 : '0;
  assign mem_wr_data_b = p2_valid ? au_res_2 : '0;

`ifdef NTT_CYCLE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt_q <= '0;
    end else if (busy && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: RAM/ROM/arith-unit models, a loop-nest NTT model,
// a table of runs, random runs, and hand-written mid-run start and reset sequences.
module tb_ntt_stage_sequencer;

  localparam int DATA_W    = 64;
  localparam int LOG_N_MAX = 12;
  localparam int ADDR_W    = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        log_n = '0;
  logic [DATA_W-1:0] q = '0;
  logic              busy, done, err;
  logic [31:0]       cycle_cnt;
  logic              mem_rd_en, mem_wr_en, tw_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr_a, mem_rd_addr_b, mem_wr_addr_a, mem_wr_addr_b;
  logic [ADDR_W-2:0] tw_rd_addr;
  logic [DATA_W-1:0] mem_rd_data_a = '0, mem_rd_data_b = '0, tw_rd_data = '0;
  logic [DATA_W-1:0] mem_wr_data_a, mem_wr_data_b;
  logic [2:0]        au_opcode;
  logic [DATA_W-1:0] au_op_a, au_op_b, au_op_w, au_op_q;
  logic [DATA_W-1:0] au_res_1 = '0, au_res_2 = '0;

  ntt_stage_sequencer #(.DATA_W(DATA_W), .LOG_N_MAX(LOG_N_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .log_n(log_n), .q(q),
    .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt),
    .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
    .mem_rd_data_a(mem_rd_data_a), .mem_rd_data_b(mem_rd_data_b),
    .mem_wr_en(mem_wr_en), .mem_wr_addr_a(mem_wr_addr_a), .mem_wr_addr_b(mem_wr_addr_b),
    .mem_wr_data_a(mem_wr_data_a), .mem_wr_data_b(mem_wr_data_b),
    .tw_rd_en(tw_rd_en), .tw_rd_addr(tw_rd_addr), .tw_rd_data(tw_rd_data),
    .au_opcode(au_opcode), .au_op_a(au_op_a), .au_op_b(au_op_b), .au_op_w(au_op_w),
    .au_op_q(au_op_q), .au_res_1(au_res_1), .au_res_2(au_res_2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory and arith models ----------------
  logic [DATA_W-1:0] ram       [0:4095];
  logic [DATA_W-1:0] init_ram  [0:4095];
  logic [DATA_W-1:0] model_ram [0:4095];
  logic [DATA_W-1:0] tw_rom    [0:2047];
  logic              load_req = 1'b0;

  function automatic logic [63:0] bf_sum(input logic [63:0] u, v, w, m);
    if (m == 0) return 64'd0;
    return (u + (v * w) % m) % m;
  endfunction

  function automatic logic [63:0] bf_diff(input logic [63:0] u, v, w, m);
    if (m == 0) return 64'd0;
    return (u % m + m - (v * w) % m) % m;
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_ram[i];
    end
    if (mem_rd_en) begin
      mem_rd_data_a <= ram[mem_rd_addr_a];
      mem_rd_data_b <= ram[mem_rd_addr_b];
    end
    if (tw_rd_en) tw_rd_data <= tw_rom[tw_rd_addr];
    if (mem_wr_en) begin
      ram[mem_wr_addr_a] <= mem_wr_data_a;
      ram[mem_wr_addr_b] <= mem_wr_data_b;
    end
    au_res_1 <= bf_sum(au_op_a, au_op_b, au_op_w, au_op_q);
    au_res_2 <= bf_diff(au_op_a, au_op_b, au_op_w, au_op_q);
  end

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  logic [23:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  int          rd_count, tw_count, wr_count;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (tw_rd_en) tw_count++;
      if (mem_rd_en) begin
        rd_count++;
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 64'(mem_rd_addr_a), 64'hFFFF);
        end else begin
          check("rd_addr_tw", 64'({mem_rd_addr_a, mem_rd_addr_b, tw_rd_addr}), 64'(exp_q.pop_front()));
        end
        rd_addr_q.push_back({mem_rd_addr_a, mem_rd_addr_b});
        rd_cyc_q.push_back(cyc);
      end
      if (mem_wr_en) begin
        wr_count++;
        if (rd_addr_q.size() == 0) begin
          check("wr_unexpected", 64'(mem_wr_addr_a), 64'hFFFF);
        end else begin
          check("wr_addr", 64'({mem_wr_addr_a, mem_wr_addr_b}), 64'(rd_addr_q.pop_front()));
          check("wr_latency", 64'(cyc - rd_cyc_q.pop_front()), 64'd2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prepare(input int ln, input int qq, input bit valid);
    int n, m, a, b, t;
    logic [63:0] u, v, p, qm;
    qm = 64'(qq);
    n = valid ? (1 << ln) : 0;
    for (int i = 0; i < 4096; i++) begin
      init_ram[i]  = 64'($urandom_range(0, qq - 1));
      model_ram[i] = init_ram[i];
    end
    for (int i = 0; i < 2048; i++) tw_rom[i] = 64'($urandom_range(0, qq - 1));
    exp_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    rd_count = 0;
    tw_count = 0;
    wr_count = 0;
    if (valid) begin
      for (int s = 0; s < ln; s++) begin
        m = 1 << s;
        for (int g = 0; g < n; g += 2 * m) begin
          for (int j = 0; j < m; j++) begin
            a = g + j;
            b = a + m;
            t = j << (ln - 1 - s);
            exp_q.push_back({12'(a), 12'(b), 11'(t)});
            u = model_ram[a];
            v = model_ram[b];
            p = (v * tw_rom[t]) % qm;
            model_ram[a] = (u + p) % qm;
            model_ram[b] = (u + qm - p) % qm;
          end
        end
      end
    end
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic pulse_start(input int ln, input int qq);
    @(posedge clk);
    #1;
    start = 1'b1;
    log_n = 4'(ln);
    q     = 64'(qq);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency counts the edges after the start-sample edge up to the one that sees done.
  task automatic wait_done(input int budget, input int poke, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (poke != 0 && i == poke) begin
        start = 1'b1;
        log_n = 4'd5;
        q     = 64'd23;
      end
      if (poke != 0 && i == poke + 1) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_case(input int ln, input int qq, input int poke, input int exp_lat, input bit exp_err);
    int lat, nb, bad, nchk;
    logic [63:0] exp_cnt;
`ifdef NTT_CYCLE_CNT_EN
    exp_cnt = 64'(exp_lat);
`else
    exp_cnt = 64'd0;
`endif
    prepare(ln, qq, !exp_err);
    pulse_start(ln, qq);
    wait_done(exp_lat + 64, poke, lat);
    check("latency", 64'(lat), 64'(exp_lat));
    check("err_at_done", 64'(err), 64'(exp_err));
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", 64'(done), 64'd0);
    check("cycle_cnt", 64'(cycle_cnt), exp_cnt);
    repeat (3) @(negedge clk);
    check("cycle_cnt_hold", 64'(cycle_cnt), exp_cnt);
    check("busy_after", 64'(busy), 64'd0);
    check("au_op_q", au_op_q, 64'(qq));
    nb = exp_err ? 0 : ln * (1 << (ln - 1));
    check("rd_count", 64'(rd_count), 64'(nb));
    check("tw_count", 64'(tw_count), 64'(nb));
    check("wr_count", 64'(wr_count), 64'(nb));
    check("reads_left", 64'(exp_q.size()), 64'd0);
    nchk = exp_err ? 16 : (1 << ln);
    bad = 0;
    for (int i = 0; i < nchk; i++) if (ram[i] !== model_ram[i]) bad++;
    check("ram_contents", 64'(bad), 64'd0);
  endtask

  typedef struct {
    int ln;
    int qv;
    int poke;
    int exp_lat;
    bit exp_err;
  } vec_t;

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    int ln, qq, lat, done_seen;

    vecs[0] = '{ln: 2,  qv: 17,  poke: 0, exp_lat: 9,     exp_err: 1'b0};
    vecs[1] = '{ln: 3,  qv: 97,  poke: 0, exp_lat: 19,    exp_err: 1'b0};
    vecs[2] = '{ln: 0,  qv: 17,  poke: 0, exp_lat: 1,     exp_err: 1'b1};
    vecs[3] = '{ln: 13, qv: 17,  poke: 0, exp_lat: 1,     exp_err: 1'b1};
    vecs[4] = '{ln: 15, qv: 31,  poke: 0, exp_lat: 1,     exp_err: 1'b1};
    vecs[5] = '{ln: 2,  qv: 17,  poke: 3, exp_lat: 9,     exp_err: 1'b0};
    vecs[6] = '{ln: 2,  qv: 17,  poke: 9, exp_lat: 9,     exp_err: 1'b0};
    vecs[7] = '{ln: 4,  qv: 97,  poke: 0, exp_lat: 41,    exp_err: 1'b0};
    vecs[8] = '{ln: 1,  qv: 5,   poke: 0, exp_lat: 4,     exp_err: 1'b0};
    vecs[9] = '{ln: 12, qv: 257, poke: 0, exp_lat: 24601, exp_err: 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("rst_rd_en", 64'({mem_rd_en, tw_rd_en, mem_wr_en}), 64'd0);
    check("rst_opcode", 64'(au_opcode), 64'd3);
    check("rst_au_op_q", au_op_q, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_case(vecs[i].ln, vecs[i].qv, vecs[i].poke, vecs[i].exp_lat, vecs[i].exp_err);
    end

    // Reset during stage 1 of a log_n=3 transform.
    prepare(3, 97, 1'b1);
    pulse_start(3, 97);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_en", 64'(mem_wr_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || mem_wr_en || mem_rd_en) done_seen++;
    end
    check("abort_quiet", 64'(done_seen), 64'd0);
    run_case(2, 17, 0, 9, 1'b0);

    // Random runs against the loop-nest model.
    for (int r = 0; r < 8; r++) begin
      ln = $urandom_range(0, 9);
      if (ln == 9) ln = 14;
      qq = $urandom_range(2, 1000);
      if (ln >= 1 && ln <= LOG_N_MAX) begin
        lat = ln * ((1 << ln) / 2 + 2) + 1;
        run_case(ln, qq, 0, lat, 1'b0);
      end else begin
        run_case(ln, qq, 0, 1, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
